// File: rtl/ldm_reg_writer_pkg.sv
// Shared types and constants for the load-multiple writeback sequencer.
package ldm_reg_writer_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned NREG       = 16;
  localparam int unsigned REG_IDX_W  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/lsb_index16.sv
// Lowest-set-bit priority encoder: 16-bit vector in, index of lowest set bit and any-set flag out.
module lsb_index16
  import ldm_reg_writer_pkg::*;
(
  input  logic [15:0]          vec,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scan high to low so the lowest set bit wins.
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx = REG_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ldm_reg_writer.sv
// Load-multiple writeback sequencer: one word read per set list bit, ascending order, each
// returned word written to its register with a one-cycle strobe.
module ldm_reg_writer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NREG-1:0]   reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              wr_en,
  output logic [3:0]        destination,
  output logic [DATA_W-1:0] LDR_mux
);
  import ldm_reg_writer_pkg::*;

  state_e                 state_q, state_d;
  logic [NREG-1:0]        list_q, list_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [REG_IDX_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]      data_q, data_d;

  logic [NREG-1:0]        enc_in;
  logic [NREG-1:0]        list_clr;
  logic [REG_IDX_W-1:0]   cur_idx;
  logic                   cur_any;

  // In IDLE the encoder screens the incoming list; afterwards it picks the next register.
  assign enc_in   = (state_q == StIdle) ? reg_list : list_q;
  assign list_clr = list_q & ~(NREG'(1) << cur_idx);

  lsb_index16 u_lsb_index16 (
    .vec (enc_in),
    .idx (cur_idx),
    .any (cur_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      list_q  <= '0;
      addr_q  <= '0;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    dest_d  = dest_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cur_any) begin
            list_d  = reg_list;
            addr_d  = base_addr & ~ADDR_W'(WORD_BYTES - 1);
            state_d = StReq;
          end else begin
            state_d = StDone;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Destination and data only change here, so they hold while wr_en is low.
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          dest_d  = cur_idx;
          state_d = StWrite;
        end
      end
      StWrite: begin
        list_d  = list_clr;
        addr_d  = addr_q + ADDR_W'(WORD_BYTES);
        state_d = (list_clr == '0) ? StDone : StReq;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    mem_req_valid = (state_q == StReq);
    mem_req_addr  = addr_q;
    wr_en         = (state_q == StWrite);
    destination   = dest_q;
    LDR_mux       = data_q;
  end

endmodule
